// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V fetch slice.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RISCV_NOP      = 32'h0000_0013;
  localparam logic [XLEN-1:0] RISCV_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous instruction buffer of fetch entries with single-cycle flush.
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  fetch_entry_t       mem_q [Depth];
  logic [AddrW:0]     wptr_q, wptr_d;
  logic [AddrW:0]     rptr_q, rptr_d;
  logic               do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign head_o  = mem_q[rptr_q[AddrW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/riscv_fetch.sv
// Fetch stage: owns the PC, issues one-at-a-time word reads and buffers {pc, inst} for decode.
module riscv_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned             WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0]  RESET_PC    = RISCV_RESET_PC,
  parameter int unsigned             FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WORD_LENGTH-1:0] imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [WORD_LENGTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [WORD_LENGTH-1:0] dec_pc,
  output logic [WORD_LENGTH-1:0] dec_inst
);

  localparam logic [WORD_LENGTH-1:0] AlignMask = ~WORD_LENGTH'(3);

  logic [WORD_LENGTH-1:0] pc_q, pc_d;
  logic [WORD_LENGTH-1:0] req_pc_q, req_pc_d;
  logic                   outstanding_q, outstanding_d;
  logic                   drop_q, drop_d;

  logic         req_fire, rsp_fire, push, pop;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry, head_entry;

  assign imem_req_valid = !rst && !outstanding_q && !fifo_full && !redirect_valid;
  assign imem_req_addr  = pc_q & AlignMask;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses are only meaningful while a request is in flight.
  assign rsp_fire       = imem_rsp_valid && outstanding_q;

  assign push            = rsp_fire && !drop_q && !redirect_valid;
  assign push_entry.pc   = req_pc_q;
  assign push_entry.inst = imem_rsp_data;

  assign dec_valid = !fifo_empty;
  assign dec_pc    = fifo_empty ? '0 : head_entry.pc;
  assign dec_inst  = fifo_empty ? RISCV_NOP : head_entry.inst;
  assign pop       = dec_valid && dec_ready;

  always_comb begin
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (req_fire) begin
      outstanding_d = 1'b1;
      req_pc_d      = imem_req_addr;
      pc_d          = imem_req_addr + WORD_LENGTH'(4);
    end
    if (rsp_fire) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    // A same-cycle response is discarded via push; a still-pending one is marked to drop.
    if (redirect_valid) begin
      pc_d = redirect_pc & AlignMask;
      if (outstanding_q && !rsp_fire) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  riscv_fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule
